// File: rtl/bcd2bin_arbiter_if.sv
// Requester and converter signals of the shared BCD-to-binary arbiter.
// The arbiter takes the slave side; clients and the converter form the master side.
interface bcd2bin_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] dig1_in;
  logic [4*NREQ-1:0] dig0_in;
  logic [NREQ-1:0]   ack;
  logic [6:0]        result;
  logic              err;
  logic              busy;
  logic              conv_start;
  logic [3:0]        conv_dig1;
  logic [3:0]        conv_dig0;
  logic              conv_ready;
  logic              conv_done_tick;
  logic [6:0]        conv_bin;

  modport slave (
    input  req, dig1_in, dig0_in, conv_ready, conv_done_tick, conv_bin,
    output ack, result, err, busy, conv_start, conv_dig1, conv_dig0
  );

  modport master (
    output req, dig1_in, dig0_in, conv_ready, conv_done_tick, conv_bin,
    input  ack, result, err, busy, conv_start, conv_dig1, conv_dig0
  );
endinterface

// File: rtl/bcd2bin_arbiter.sv
// Round-robin arbiter sharing one 2-digit BCD-to-binary converter among NREQ clients.
// Non-BCD digits are answered with err directly; a hung converter is cut off after TIMEOUT cycles.
module bcd2bin_arb_lane #(
  parameter int IDX_W = 2,
  parameter int IDX   = 0
) (
  input  logic [3:0]       dig1,
  input  logic [3:0]       dig0,
  input  logic [IDX_W-1:0] gnt,
  input  logic             in_resp,
  output logic             bcd_ok,
  output logic             ack
);
  assign bcd_ok = (dig1 <= 4'd9) && (dig0 <= 4'd9);
  assign ack    = in_resp && (gnt == IDX_W'(IDX));
endmodule

module bcd2bin_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  bcd2bin_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       gnt, last, nxt, cand;
  logic                   found;
  logic [CNT_W-1:0]       cnt;
  logic [6:0]             result_q;
  logic                   err_q;
  logic [3:0]             cd1, cd0;
  logic [NREQ-1:0][3:0]   d1_v, d0_v;
  logic [NREQ-1:0]        bcd_ok, ack_v;

  assign d1_v = bus.dig1_in;
  assign d0_v = bus.dig0_in;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    bcd2bin_arb_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
      .dig1    (d1_v[i]),
      .dig0    (d0_v[i]),
      .gnt     (gnt),
      .in_resp (state == RESP),
      .bcd_ok  (bcd_ok[i]),
      .ack     (ack_v[i])
    );
  end

  // Search starts just past the last winner so every requester is served within NREQ-1 others.
  always_comb begin
    found = 1'b0;
    nxt   = last;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last     <= IDX_W'(NREQ - 1);
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cd1      <= '0;
      cd0      <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt <= nxt;
          cd1 <= d1_v[nxt];
          cd0 <= d0_v[nxt];
          if (!bcd_ok[nxt]) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= RESP;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: if (bus.conv_ready) begin
          cnt   <= '0;
          state <= WAIT;
        end
        // A completion in the timeout cycle still counts as success.
        WAIT: begin
          if (bus.conv_done_tick) begin
            result_q <= bus.conv_bin;
            err_q    <= 1'b0;
            state    <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.conv_start = (state == ISSUE) && bus.conv_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.ack        = ack_v;
  assign bus.result     = result_q;
  assign bus.err        = err_q;
  assign bus.conv_dig1  = cd1;
  assign bus.conv_dig0  = cd0;
endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a nominal 8-cycle converter model.
module tb_bcd2bin_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  logic model_nodone;
  int   cd;
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd2bin_arbiter_if #(.NREQ(NREQ)) bus ();

  bcd2bin_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Converter model: done_tick 8 cycles after the start cycle.
  always @(posedge clk) begin
    bus.conv_done_tick <= 1'b0;
    if (rst) begin
      cd           <= 0;
      bus.conv_bin <= '0;
    end else if (bus.conv_start) begin
      cd           <= 8;
      bus.conv_bin <= 7'(int'(bus.conv_dig1) * 10 + int'(bus.conv_dig0));
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 2 && !model_nodone) bus.conv_done_tick <= 1'b1;
    end
  end

  task automatic wait_ack(output int lat, output logic [NREQ-1:0] a, output logic [6:0] r,
                          output logic e);
    lat = 0; a = '0; r = '0; e = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) begin
        lat = c; a = bus.ack; r = bus.result; e = bus.err;
        break;
      end
    end
  endtask

  task automatic do_txn(input int i, input logic [3:0] d1, input logic [3:0] d0,
                        output int lat, output int st, output logic [NREQ-1:0] a,
                        output logic [6:0] r, output logic e);
    lat = 0; st = 0; a = '0; r = '0; e = 1'b0;
    @(posedge clk); #1;
    bus.dig1_in[4*i +: 4] = d1;
    bus.dig0_in[4*i +: 4] = d0;
    bus.req[i] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.conv_start && st == 0) st = c;
      if (bus.ack != '0) begin
        lat = c; a = bus.ack; r = bus.result; e = bus.err;
        break;
      end
    end
    bus.req[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.ack, bus.result, bus.err, bus.conv_start, bus.conv_dig1, bus.conv_dig0} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: ack=%b result=%0d err=%b start=%b dig=%h%h want all 0",
               bus.ack, bus.result, bus.err, bus.conv_start, bus.conv_dig1, bus.conv_dig0);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_convert();
    int lat, st; logic [NREQ-1:0] a; logic [6:0] r; logic e;
    do_txn(0, 4'd4, 4'd2, lat, st, a, r, e);
    n_tests++;
    if (st !== 1 || lat !== 10) begin
      n_fail++; $display("FAIL conv42 timing: start=%0d ack=%0d want 1/10", st, lat);
    end
    n_tests++;
    if (a !== 4'b0001 || r !== 7'b0101010 || e !== 1'b0) begin
      n_fail++; $display("FAIL conv42 data: ack=%b result=%0d err=%b want 0001/42/0", a, r, e);
    end
    do_txn(2, 4'd9, 4'd9, lat, st, a, r, e);
    n_tests++;
    if (lat !== 10 || a !== 4'b0100 || r !== 7'd99 || e !== 1'b0) begin
      n_fail++; $display("FAIL conv99: lat=%0d ack=%b result=%0d err=%b want 10/0100/99/0", lat, a, r, e);
    end
    do_txn(1, 4'd0, 4'd0, lat, st, a, r, e);
    n_tests++;
    if (lat !== 10 || a !== 4'b0010 || r !== 7'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL conv00: lat=%0d ack=%b result=%0d err=%b want 10/0010/0/0", lat, a, r, e);
    end
  endtask

  task automatic test_round_robin();
    int lat, st; logic [NREQ-1:0] a; logic [6:0] r; logic e;
    logic [NREQ-1:0] exp_a [4];
    logic [6:0]      exp_r [4];
    exp_a[0] = 4'b0001; exp_a[1] = 4'b0100; exp_a[2] = 4'b0001; exp_a[3] = 4'b0100;
    exp_r[0] = 7'd10;   exp_r[1] = 7'd25;   exp_r[2] = 7'd10;   exp_r[3] = 7'd25;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dig1_in[3:0] = 4'd1;  bus.dig0_in[3:0] = 4'd0;
    bus.dig1_in[11:8] = 4'd2; bus.dig0_in[11:8] = 4'd5;
    bus.req[0] = 1'b1; bus.req[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(lat, a, r, e);
      if (k == 3) begin bus.req[0] = 1'b0; bus.req[2] = 1'b0; end
      n_tests++;
      if (a !== exp_a[k] || r !== exp_r[k] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL rr02 grant %0d: ack=%b result=%0d err=%b want %b/%0d/0", k, a, r, e, exp_a[k], exp_r[k]);
      end
    end
    do_txn(3, 4'd0, 4'd3, lat, st, a, r, e);
    n_tests++;
    if (a !== 4'b1000 || r !== 7'd3) begin
      n_fail++; $display("FAIL rr last3: ack=%b result=%0d want 1000/3", a, r);
    end
    @(posedge clk); #1;
    bus.dig1_in[7:4] = 4'd6;   bus.dig0_in[7:4] = 4'd1;
    bus.dig1_in[15:12] = 4'd8; bus.dig0_in[15:12] = 4'd8;
    bus.req[1] = 1'b1; bus.req[3] = 1'b1;
    wait_ack(lat, a, r, e);
    bus.req[1] = 1'b0;
    n_tests++;
    if (a !== 4'b0010 || r !== 7'd61) begin
      n_fail++; $display("FAIL rr13 first: ack=%b result=%0d want 0010/61", a, r);
    end
    wait_ack(lat, a, r, e);
    bus.req[3] = 1'b0;
    n_tests++;
    if (a !== 4'b1000 || r !== 7'd88) begin
      n_fail++; $display("FAIL rr13 second: ack=%b result=%0d want 1000/88", a, r);
    end
  endtask

  task automatic test_invalid();
    int lat, st; logic [NREQ-1:0] a; logic [6:0] r; logic e;
    do_txn(1, 4'd1, 4'hA, lat, st, a, r, e);
    n_tests++;
    if (lat !== 1 || st !== 0) begin
      n_fail++; $display("FAIL inv1A timing: ack=%0d start=%0d want 1/0", lat, st);
    end
    n_tests++;
    if (a !== 4'b0010 || r !== 7'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL inv1A data: ack=%b result=%0d err=%b want 0010/0/1", a, r, e);
    end
    do_txn(0, 4'hF, 4'd9, lat, st, a, r, e);
    n_tests++;
    if (lat !== 1 || st !== 0 || a !== 4'b0001 || e !== 1'b1) begin
      n_fail++; $display("FAIL invF9: lat=%0d start=%0d ack=%b err=%b want 1/0/0001/1", lat, st, a, e);
    end
  endtask

  task automatic test_timeout_stall();
    int lat = 0, st = 0, bad = 0;
    logic [NREQ-1:0] a = '0; logic [6:0] r = '0; logic e = 1'b0;
    @(posedge clk); #1;
    bus.conv_ready = 1'b0;
    model_nodone   = 1'b1;
    bus.dig1_in[11:8] = 4'd3; bus.dig0_in[11:8] = 4'd3;
    bus.req[2] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin bus.conv_ready = 1'b1; #1; end
      if (c <= 5 && (bus.conv_start !== 1'b0 || bus.busy !== 1'b1)) bad++;
      if (bus.conv_start && st == 0) st = c;
      if (bus.ack != '0) begin
        lat = c; a = bus.ack; r = bus.result; e = bus.err;
        break;
      end
    end
    bus.req[2]   = 1'b0;
    model_nodone = 1'b0;
    n_tests++;
    if (bad !== 0 || st !== 6) begin
      n_fail++; $display("FAIL stall: bad_cycles=%0d start=%0d want 0/6", bad, st);
    end
    n_tests++;
    if (lat !== 6 + 1 + TIMEOUT) begin
      n_fail++; $display("FAIL timeout latency: ack=%0d want %0d", lat, 6 + 1 + TIMEOUT);
    end
    n_tests++;
    if (a !== 4'b0100 || r !== 7'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL timeout data: ack=%b result=%0d err=%b want 0100/0/1", a, r, e);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, st, acks = 0; logic [NREQ-1:0] a; logic [6:0] r; logic e;
    @(posedge clk); #1;
    bus.dig1_in[3:0] = 4'd1; bus.dig0_in[3:0] = 4'd2;
    bus.req[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.conv_dig1 !== 4'd0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-wait reset: busy=%b ack=%b dig1=%0d err=%b want 0/0000/0/0",
               bus.busy, bus.ack, bus.conv_dig1, bus.err);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0 || bus.busy) acks++;
    end
    n_tests++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL post-reset quiet: stray ack/busy cycles=%0d want 0", acks);
    end
    do_txn(3, 4'd7, 4'd5, lat, st, a, r, e);
    n_tests++;
    if (lat !== 10 || a !== 4'b1000 || r !== 7'd75 || e !== 1'b0) begin
      n_fail++; $display("FAIL conv75: lat=%0d ack=%b result=%0d err=%b want 10/1000/75/0", lat, a, r, e);
    end
  endtask

  initial begin
    rst            = 1'b1;
    model_nodone   = 1'b0;
    bus.conv_ready = 1'b1;
    bus.req        = '0;
    bus.dig1_in    = '0;
    bus.dig0_in    = '0;
    test_reset();
    test_convert();
    test_round_robin();
    test_invalid();
    test_timeout_stall();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
